// File: rtl/prim_reqack_src_queue_if.sv
// prim_reqack_src_queue_if: bundles the upstream valid/ready stream, the REQ/ACK
// pair towards the synchronizer and the status outputs of prim_reqack_src_queue.
//
// Signals:
//   in_valid  upstream word valid             (master -> slave)
//   in_ready  queue can accept a word          (slave -> master)
//   in_data   upstream word, Width bits        (master -> slave)
//   src_req   REQ to synchronizer              (slave -> master)
//   src_ack   one-cycle ACK from synchronizer  (master -> slave)
//   data      word under handshake             (slave -> master)
//   depth     entries held incl. in-flight     (slave -> master)
//   err       sticky stray-ACK flag            (slave -> master)
//
// The slave modport is the queue itself; master is its environment.

interface prim_reqack_src_queue_if #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
);
    localparam int unsigned DepthW = $clog2(Depth + 1);

    logic              in_valid;
    logic              in_ready;
    logic [Width-1:0]  in_data;
    logic              src_req;
    logic              src_ack;
    logic [Width-1:0]  data;
    logic [DepthW-1:0] depth;
    logic              err;

    modport slave (
        input  in_valid,
        input  in_data,
        input  src_ack,
        output in_ready,
        output src_req,
        output data,
        output depth,
        output err
    );

    modport master (
        output in_valid,
        output in_data,
        output src_ack,
        input  in_ready,
        input  src_req,
        input  data,
        input  depth,
        input  err
    );
endinterface

// File: rtl/prim_reqack_src_queue.sv
// prim_reqack_src_queue: SRC-domain front end for the REQ/ACK data synchronizer.
// Words arrive on a valid/ready stream, are buffered in a Depth-entry FIFO and
// each one is sent with its own REQ/ACK handshake. The head word is presented on
// data while REQ is high and cannot change until the ACK cycle, so the data-hold
// rule of the synchronizer holds without any extra capture register.
//
// Ports:
//   clk_i   SRC-domain clock
//   rst_i   synchronous, active-high reset
//   bus_if  slave modport of prim_reqack_src_queue_if
//           (in_valid/in_ready/in_data, src_req/src_ack, data, depth, err)

module prim_reqack_src_queue #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input logic                     clk_i,
    input logic                     rst_i,
    prim_reqack_src_queue_if.slave  bus_if
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] PtrMax = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] CntMax = CntW'(Depth);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e           state_q, state_d;
    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             err_q, err_d;

    logic full;
    logic push;
    logic pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrMax) ? '0 : p + 1'b1;
    endfunction

    assign full = (count_q == CntMax);
    assign push = bus_if.in_valid & ~full;
    assign pop  = (state_q == StReq) & bus_if.src_ack;

    // Ready depends on count only; a slot freed by an ACK shows up next cycle.
    assign bus_if.in_ready = ~full;
    assign bus_if.depth    = count_q;
    assign bus_if.err      = err_q;

    // FIFO bookkeeping
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // A stray ACK has no word to retire; flag it until reset.
    always_comb begin
        err_d = err_q;
        if (bus_if.src_ack && (state_q == StIdle)) begin
            err_d = 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if ((count_q != '0) || push) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                // count_d already folds in pop and any same-cycle push, so REQ
                // stays high back-to-back while anything remains queued.
                if (pop && (count_d == '0)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus_if.src_req = 1'b0;
        bus_if.data    = '0;
        if (state_q == StReq) begin
            bus_if.src_req = 1'b1;
            bus_if.data    = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Storage is not reset; only valid entries are ever read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus_if.in_data;
        end
    end

    // While a handshake is open the presented word must not move. A write can
    // never land on rd_ptr here because that would require a full queue.
    a_data_stable: assert property (@(posedge clk_i)
        (!rst_i && bus_if.src_req && !bus_if.src_ack) |=> $stable(bus_if.data));

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !bus_if.in_ready |-> !push);

    a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= CntMax);

endmodule
